// File: rtl/data_cal_seq_if.sv
// Job, datapath and response signals of the data_cal sequencer.
interface data_cal_seq_if;
  // job request
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_mask;
  // datapath drive and return
  logic [15:0] cal_d;
  logic [1:0]  cal_sel;
  logic [4:0]  cal_out;
  logic        cal_validout;
  // response
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_sum1;
  logic [4:0]  res_sum2;
  logic [4:0]  res_sum3;
  logic [6:0]  res_total;
  logic        res_err;

  // sequencer side
  modport slave (
    input  in_valid, in_data, in_mask, cal_out, cal_validout, res_ready,
    output in_ready, cal_d, cal_sel, res_valid,
           res_sum1, res_sum2, res_sum3, res_total, res_err
  );

  // job producer / datapath / consumer side
  modport master (
    output in_valid, in_data, in_mask, cal_out, cal_validout, res_ready,
    input  in_ready, cal_d, cal_sel, res_valid,
           res_sum1, res_sum2, res_sum3, res_total, res_err
  );
endinterface

// File: rtl/data_cal_seq.sv
// Sequencer for the data_cal nibble-sum datapath: loads a word with sel=0,
// issues the enabled sel codes 1..3 in ascending order, captures each
// registered sum one cycle later and presents the results on a held response.
module data_cal_seq (
  input  logic           clk,
  input  logic           rst,
  data_cal_seq_if.slave  bus
);

  localparam int unsigned DW = 16;
  localparam int unsigned MW = 3;
  localparam int unsigned CW = 2;
  localparam int unsigned SW = 5;
  localparam int unsigned TW = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q,  data_d;
  logic [MW-1:0] mask_q,  mask_d;
  logic [CW-1:0] code_q,  code_d;   // code being issued this cycle
  logic [CW-1:0] tag_q,   tag_d;    // code issued last cycle, 0 = none
  logic [SW-1:0] sum1_q,  sum1_d;
  logic [SW-1:0] sum2_q,  sum2_d;
  logic [SW-1:0] sum3_q,  sum3_d;
  logic          err_q,   err_d;
  logic [CW-1:0] nxt_code;
  logic [CW-1:0] first_code;
  logic          capture_en;

  // Lowest enabled code strictly above 'after'; 0 when none remain.
  function automatic logic [CW-1:0] next_code(input logic [MW-1:0] mask,
                                              input logic [CW-1:0] after);
    logic [CW-1:0] r;
    r = '0;
    for (int k = MW; k >= 1; k--) begin
      if (mask[k-1] && (CW'(k) > after)) r = CW'(k);
    end
    return r;
  endfunction

  assign nxt_code   = next_code(mask_q, code_q);
  assign first_code = next_code(bus.in_mask, CW'(0));
  assign capture_en = ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)) &&
                      (tag_q != '0);

  // Next-state, capture and datapath drive
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mask_d      = mask_q;
    code_d      = code_q;
    tag_d       = tag_q;
    sum1_d      = sum1_q;
    sum2_d      = sum2_q;
    sum3_d      = sum3_q;
    err_d       = err_q;
    bus.in_ready  = 1'b0;
    bus.cal_sel   = '0;
    bus.cal_d     = data_q;
    bus.res_valid = 1'b0;

    // The sum for the tagged code arrives one cycle after it was issued
    if (capture_en) begin
      unique case (tag_q)
        2'd1:    sum1_d = bus.cal_out;
        2'd2:    sum2_d = bus.cal_out;
        2'd3:    sum3_d = bus.cal_out;
        default: ;
      endcase
      if (!bus.cal_validout) err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        bus.cal_d    = bus.in_data;
        tag_d        = '0;
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          mask_d  = bus.in_mask;
          code_d  = first_code;
          sum1_d  = '0;
          sum2_d  = '0;
          sum3_d  = '0;
          err_d   = 1'b0;
          state_d = (bus.in_mask != '0) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        bus.cal_sel = code_q;
        tag_d       = code_q;
        if (nxt_code == '0) begin
          code_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          code_d  = nxt_code;
        end
      end
      ST_DRAIN: begin
        tag_d   = '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and job registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      code_q  <= '0;
      tag_q   <= '0;
      sum1_q  <= '0;
      sum2_q  <= '0;
      sum3_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      code_q  <= code_d;
      tag_q   <= tag_d;
      sum1_q  <= sum1_d;
      sum2_q  <= sum2_d;
      sum3_q  <= sum3_d;
      err_q   <= err_d;
    end
  end

  assign bus.res_sum1  = sum1_q;
  assign bus.res_sum2  = sum2_q;
  assign bus.res_sum3  = sum3_q;
  assign bus.res_err   = err_q;
  // Three 5-bit sums fit in 7 bits, so the total cannot wrap
  assign bus.res_total = TW'(sum1_q) + TW'(sum2_q) + TW'(sum3_q);

endmodule

// File: tb/tb_data_cal_seq.sv
// Directed bench for data_cal_seq with a behavioural data_cal model.
module tb_data_cal_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [1:0]  err_code;     // sel code whose validout the model withholds
  logic [15:0] dp_d;

  data_cal_seq_if bus ();

  data_cal_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // data_cal model: sel=0 loads d, sel=k registers nibble k + nibble 0
  always_ff @(posedge clk) begin
    if (bus.cal_sel == 2'd0) dp_d <= bus.cal_d;
    case (bus.cal_sel)
      2'd1:    bus.cal_out <= 5'(dp_d[7:4])   + 5'(dp_d[3:0]);
      2'd2:    bus.cal_out <= 5'(dp_d[11:8])  + 5'(dp_d[3:0]);
      2'd3:    bus.cal_out <= 5'(dp_d[15:12]) + 5'(dp_d[3:0]);
      default: bus.cal_out <= 5'd0;
    endcase
    bus.cal_validout <= (bus.cal_sel != 2'd0) && (bus.cal_sel != err_code);
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accept one job and run until res_valid; inputs are scrambled after accept.
  task automatic run_job(input logic [15:0] data, input logic [2:0] mask,
                         output int lat, output logic [15:0] seq,
                         output logic bad);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_mask  = mask;
    #1;
    seq = 16'(bus.cal_sel);
    lat = 0;
    bad = 1'b0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = ~data;
      bus.in_mask  = ~mask;
      #1;
      if (bus.cal_d !== data || bus.in_ready !== 1'b0) bad = 1'b1;
      if (!bus.res_valid) seq = (seq << 2) | 16'(bus.cal_sel);
    end while (!bus.res_valid && lat < 20);
  endtask

  task automatic check_res(input string tag, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] s3,
                           input logic [6:0] tot, input logic err);
    check_eq({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check_eq({tag, "_sum1"},  32'(bus.res_sum1),  32'(s1));
    check_eq({tag, "_sum2"},  32'(bus.res_sum2),  32'(s2));
    check_eq({tag, "_sum3"},  32'(bus.res_sum3),  32'(s3));
    check_eq({tag, "_total"}, 32'(bus.res_total), 32'(tot));
    check_eq({tag, "_err"},   32'(bus.res_err),   32'(err));
  endtask

  // Consume the response (res_ready already high) and expect IDLE again
  task automatic finish_resp(input string tag);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq({tag, "_idle_ready"}, 32'(bus.in_ready),  32'd1);
    check_eq({tag, "_idle_valid"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] seq;
    logic        bad;
    logic        seen;

    rst           = 1'b1;
    err_code      = 2'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h1234;
    bus.in_mask   = 3'b000;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_cal_sel",   32'(bus.cal_sel),   32'd0);
    check_eq("rst_cal_d",     32'(bus.cal_d),     32'h1234);
    check_eq("rst_total",     32'(bus.res_total), 32'd0);
    check_eq("rst_err",       32'(bus.res_err),   32'd0);

    // full mask
    run_job(16'hF5A3, 3'b111, lat, seq, bad);
    check_eq("full_lat", 32'(lat), 32'd5);
    check_eq("full_seq", 32'(seq), 32'h06C);
    check_eq("full_latched", 32'(bad), 32'd0);
    check_res("full", 5'd13, 5'd8, 5'd18, 7'd39, 1'b0);
    finish_resp("full");

    // sparse mask: 1 then 3 back-to-back
    run_job(16'hF5A3, 3'b101, lat, seq, bad);
    check_eq("sparse_lat", 32'(lat), 32'd4);
    check_eq("sparse_seq", 32'(seq), 32'h01C);
    check_eq("sparse_latched", 32'(bad), 32'd0);
    check_res("sparse", 5'd13, 5'd0, 5'd18, 7'd31, 1'b0);
    finish_resp("sparse");

    // single code 2 on another word
    run_job(16'h1234, 3'b010, lat, seq, bad);
    check_eq("single_lat", 32'(lat), 32'd3);
    check_eq("single_seq", 32'(seq), 32'h008);
    check_res("single", 5'd0, 5'd6, 5'd0, 7'd6, 1'b0);
    finish_resp("single");

    // maximum values, no truncation
    run_job(16'hFFFF, 3'b111, lat, seq, bad);
    check_eq("max_lat", 32'(lat), 32'd5);
    check_res("max", 5'd30, 5'd30, 5'd30, 7'd90, 1'b0);
    finish_resp("max");

    // empty mask with backpressure; a pending request must not be taken
    bus.res_ready = 1'b0;
    run_job(16'hABCD, 3'b000, lat, seq, bad);
    check_eq("empty_lat", 32'(lat), 32'd1);
    check_eq("empty_seq", 32'(seq), 32'd0);
    check_eq("empty_latched", 32'(bad), 32'd0);
    check_res("empty", 5'd0, 5'd0, 5'd0, 7'd0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_mask  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("bp_valid", 32'(bus.res_valid), 32'd1);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_total", 32'(bus.res_total), 32'd0);
      check_eq("bp_cal_d", 32'(bus.cal_d), 32'hABCD);
    end
    bus.res_ready = 1'b1;
    finish_resp("bp");
    bus.in_valid = 1'b0;

    // withheld validout on the second capture
    err_code = 2'd2;
    run_job(16'hF5A3, 3'b111, lat, seq, bad);
    check_eq("err_lat", 32'(lat), 32'd5);
    check_res("err", 5'd13, 5'd8, 5'd18, 7'd39, 1'b1);
    finish_resp("err");
    err_code = 2'd0;

    // error flag does not survive into the next job
    run_job(16'hF5A3, 3'b101, lat, seq, bad);
    check_res("clr", 5'd13, 5'd0, 5'd18, 7'd31, 1'b0);
    finish_resp("clr");

    // reset during ISSUE after sum1 has been captured
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hF5A3;
    bus.in_mask  = 3'b111;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    #1;
    check_eq("mid_sel", 32'(bus.cal_sel), 32'd3);
    check_eq("mid_sum1", 32'(bus.res_sum1), 32'd13);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("mrst_valid", 32'(bus.res_valid), 32'd0);
    check_eq("mrst_sel", 32'(bus.cal_sel), 32'd0);
    check_eq("mrst_sum1", 32'(bus.res_sum1), 32'd0);
    check_eq("mrst_total", 32'(bus.res_total), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.res_valid !== 1'b0) seen = 1'b1;
    end
    check_eq("mrst_no_stale", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cal_seq.md
# data_cal_seq

Sequencing controller for the nibble-sum datapath `data_cal`. It accepts one 16-bit job over a valid/ready handshake and loads the word into the datapath with `sel`=0. It then issues the enabled `sel` codes 1..3 in ascending order and captures each registered 5-bit sum, together with a 7-bit total. The result is presented on a held valid/ready response port. The block sits between a job producer and a single `data_cal` instance and is the only driver of that instance's `d`/`sel`.

## Interface
- No parameters; all widths are fixed by the datapath.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  job request.
- `in_ready`  out  1  job accepted when `in_valid && in_ready`.
- `in_data`  in  16  word to process.
- `in_mask`  in  3  bit k-1 enables `sel`=k (k=1..3).
- `cal_d`  out  16  drives `data_cal.d`.
- `cal_sel`  out  2  drives `data_cal.sel`.
- `cal_out`  in  5  from `data_cal.out`.
- `cal_validout`  in  1  from `data_cal.validout`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when `res_valid && res_ready`.
- `res_sum1` / `res_sum2` / `res_sum3`  out  5 each  sum for `sel`=1/2/3; 0 if disabled.
- `res_total`  out  7  zero-extended sum of the three slots, range 0..90.
- `res_err`  out  1  an expected `cal_validout` was low.

## Operation
- States: IDLE, ISSUE, DRAIN, RESP.
- **IDLE**
  - `in_ready`=1, `cal_sel`=0, `cal_d`=`in_data`. The datapath therefore latches the word on the acceptance edge.
  - On accept, latch `in_data` and `in_mask`, and clear the slots and `res_err`.
  - Next state is ISSUE if the mask is nonzero, otherwise RESP.
- **ISSUE**
  - One cycle per enabled code, in ascending order; disabled codes are skipped with no gap cycles.
  - `cal_sel`=current code. A 2-bit tag register records the code issued in the previous cycle.
  - After the last enabled code, go to DRAIN.
- **DRAIN**: one cycle, `cal_sel`=0, `cal_d`=latched word. Reloading the same word is harmless.
- **Capture rule** (ISSUE and DRAIN)
  - When the tag is valid, write `cal_out` into the slot named by the tag.
  - If `cal_validout`=0 in that cycle, set `res_err` (sticky for the job) and still write `cal_out`.
- **RESP**
  - `res_valid`=1. All result outputs are held stable until the handshake completes.
  - `cal_sel`=0, `cal_d`=latched word, `in_ready`=0.
  - On `res_ready`, go to IDLE.
- `res_total` is computed combinationally from the slots, zero-extended to 7 bits. It never wraps.
- In any state other than IDLE, `cal_d` is the latched word, never the live `in_data`.

## Timing
- **Reset**
  - State = IDLE.
  - `in_ready`=1, `res_valid`=0, `cal_sel`=0, `cal_d`=`in_data`.
  - All slots, `res_total` and `res_err` are 0; the tag is invalid.
  - Reset mid-job discards the job; no response is produced.
- **Latency**
  - Accept at edge A with n enabled codes: `res_valid` rises n+2 cycles after A.
  - n=0: `res_valid` rises 1 cycle after A.
- **Datapath alignment**: `cal_out` is sampled exactly one cycle after its `sel` is driven, matching the datapath's registered output.
- **Throughput**: one job per n+3 cycles at best. `in_ready` is low from the cycle after accept until the cycle after the response handshake.
- **Overlap**: no accept is possible in the same cycle as a response handshake.
- **Stability**: `in_data`/`in_mask` changes after acceptance have no effect on the current job.

## Test plan
- **Full mask**: `in_data`=16'hF5A3, `in_mask`=3'b111.
  - `cal_sel` sequence is 0,1,2,3,0.
  - `res_sum1`=13, `res_sum2`=8, `res_sum3`=18, `res_total`=39, `res_err`=0.
  - `res_valid` rises 5 cycles after accept.
- **Sparse mask**: `in_data`=16'hF5A3, `in_mask`=3'b101.
  - Issues 1 then 3 back-to-back.
  - `res_sum1`=13, `res_sum2`=0, `res_sum3`=18, `res_total`=31.
  - Latency 4 cycles.
- **Maximum values**: `in_data`=16'hFFFF, mask 3'b111.
  - Each sum is 30 and `res_total`=90, with no truncation.
- **Empty mask and backpressure**:
  - Mask 3'b000 gives `res_valid` 1 cycle after accept, with all sums and the total 0.
  - Holding `res_ready`=0 for 3 cycles keeps all outputs stable and `in_ready`=0.
  - IDLE returns the cycle after `res_ready`.
- **Error and reset**:
  - Datapath model forces `cal_validout`=0 on the second capture with mask 3'b111: `res_err`=1 and the other sums are still correct.
  - Separately, asserting `rst` during ISSUE returns IDLE with `res_valid`=0 and all outputs zeroed next cycle; no stale response appears.
